// File: rtl/ex_muldiv.sv
`default_nettype none
// ============================================================================
// Module      : ex_muldiv
// Description : Iterative 32x32 multiply / 32/32 divide unit for the EX stage.
//               Executes MULT/MULTU (shift-add) and DIV/DIVU (restoring) on
//               operand magnitudes over 32 cycles. A final cycle applies the
//               sign correction and writes the unit's own HI/LO registers.
//               MTHI/MTLO write HI/LO directly while the unit is idle.
// Revision    : 1.0 - initial release
// ============================================================================
module ex_muldiv (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        Start,
    input  logic [1:0]  Op,
    input  logic [31:0] SrcA,
    input  logic [31:0] SrcB,
    input  logic        Flush,
    input  logic        WriteHi,
    input  logic        WriteLo,
    input  logic [31:0] WriteData,
    output logic        Busy,
    output logic        Done,
    output logic [31:0] HI,
    output logic [31:0] LO
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIX  = 2'd2
    } state_t;

    localparam logic [4:0] c_LAST_ITER = 5'd31;

    state_t      r_state;
    logic        r_is_div;     // latched Op[1]
    logic        r_neg_res;    // product / quotient must be negated
    logic        r_neg_rem;    // remainder must be negated (follows dividend sign)
    logic        r_div_zero;   // divisor was zero
    logic [4:0]  r_cnt;        // iteration counter 0..31
    logic [31:0] r_m;          // multiplicand magnitude (mul) or divisor magnitude (div)
    logic [31:0] r_srca;       // original dividend, returned in HI on divide by zero
    logic [63:0] r_acc;        // mul: {partial product, multiplier}; div: [31:0] dividend -> quotient
    logic [31:0] r_rem;        // div: partial remainder
    logic [31:0] r_hi;
    logic [31:0] r_lo;
    logic        r_busy;
    logic        r_done;

    // Operand magnitudes: only the signed ops (Op[0]=1) take absolute values.
    logic        w_signed;
    logic        w_a_neg;
    logic        w_b_neg;
    logic [31:0] w_abs_a;
    logic [31:0] w_abs_b;

    assign w_signed = Op[0];
    assign w_a_neg  = w_signed & SrcA[31];
    assign w_b_neg  = w_signed & SrcB[31];
    assign w_abs_a  = w_a_neg ? (~SrcA + 32'd1) : SrcA;
    assign w_abs_b  = w_b_neg ? (~SrcB + 32'd1) : SrcB;

    // Multiply step: add multiplicand into the upper half when the multiplier
    // LSB is set; the 33-bit sum keeps the carry that shifts into bit 63.
    logic [32:0] w_msum;
    assign w_msum = {1'b0, r_acc[63:32]} + (r_acc[0] ? {1'b0, r_m} : 33'd0);

    // Divide step: 33-bit partial remainder after shifting in the next dividend
    // bit. The trial difference fits in 32 bits whenever it is kept, since the
    // new remainder is always smaller than the divisor.
    logic [32:0] w_dshift;
    logic        w_ge;
    logic [31:0] w_ddiff;
    assign w_dshift = {r_rem, r_acc[31]};
    assign w_ge     = (w_dshift >= {1'b0, r_m});
    assign w_ddiff  = w_dshift[31:0] - r_m;

    // Sign-corrected results presented in FIX.
    logic [63:0] w_prod;
    logic [31:0] w_quo;
    logic [31:0] w_remf;
    assign w_prod = r_neg_res ? (~r_acc + 64'd1) : r_acc;
    assign w_quo  = r_neg_res ? (~r_acc[31:0] + 32'd1) : r_acc[31:0];
    assign w_remf = r_neg_rem ? (~r_rem + 32'd1) : r_rem;

    // Control FSM and datapath: launch in IDLE, iterate in CALC, correct/write in FIX.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_is_div   <= 1'b0;
            r_neg_res  <= 1'b0;
            r_neg_rem  <= 1'b0;
            r_div_zero <= 1'b0;
            r_cnt      <= 5'd0;
            r_m        <= 32'd0;
            r_srca     <= 32'd0;
            r_acc      <= 64'd0;
            r_rem      <= 32'd0;
            r_hi       <= 32'd0;
            r_lo       <= 32'd0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (Flush) begin
                        // squash: nothing launched, no HI/LO writes this cycle
                    end else if (Start) begin
                        r_is_div   <= Op[1];
                        r_neg_res  <= w_a_neg ^ w_b_neg;
                        r_neg_rem  <= w_a_neg;
                        r_div_zero <= (SrcB == 32'd0);
                        r_srca     <= SrcA;
                        r_cnt      <= 5'd0;
                        r_rem      <= 32'd0;
                        r_m        <= Op[1] ? w_abs_b : w_abs_a;
                        r_acc      <= {32'd0, (Op[1] ? w_abs_a : w_abs_b)};
                        r_busy     <= 1'b1;
                        r_state    <= S_CALC;
                    end else begin
                        if (WriteHi) r_hi <= WriteData;
                        if (WriteLo) r_lo <= WriteData;
                    end
                end
                S_CALC: begin
                    if (Flush) begin
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end else begin
                        if (r_is_div) begin
                            r_rem        <= w_ge ? w_ddiff : w_dshift[31:0];
                            r_acc[31:0]  <= {r_acc[30:0], w_ge};
                        end else begin
                            r_acc <= {w_msum, r_acc[31:1]};
                        end
                        r_cnt <= r_cnt + 5'd1;
                        if (r_cnt == c_LAST_ITER) r_state <= S_FIX;
                    end
                end
                S_FIX: begin
                    if (!Flush) begin
                        if (!r_is_div) begin
                            r_hi <= w_prod[63:32];
                            r_lo <= w_prod[31:0];
                        end else if (r_div_zero) begin
                            r_hi <= r_srca;
                            r_lo <= 32'hFFFF_FFFF;
                        end else begin
                            r_hi <= w_remf;
                            r_lo <= w_quo;
                        end
                        r_done <= 1'b1;
                    end
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign Busy = r_busy;
    assign Done = r_done;
    assign HI   = r_hi;
    assign LO   = r_lo;

endmodule
`default_nettype wire

// File: tb/tb_ex_muldiv.sv
`default_nettype none
// ============================================================================
// Module      : tb_ex_muldiv
// Description : Directed self-checking bench for ex_muldiv.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ex_muldiv;

    logic        clk;
    logic        rst_n;
    logic        Start;
    logic [1:0]  Op;
    logic [31:0] SrcA;
    logic [31:0] SrcB;
    logic        Flush;
    logic        WriteHi;
    logic        WriteLo;
    logic [31:0] WriteData;
    logic        Busy;
    logic        Done;
    logic [31:0] HI;
    logic [31:0] LO;

    int n_tests = 0;
    int n_fail  = 0;

    ex_muldiv dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .Start     (Start),
        .Op        (Op),
        .SrcA      (SrcA),
        .SrcB      (SrcB),
        .Flush     (Flush),
        .WriteHi   (WriteHi),
        .WriteLo   (WriteLo),
        .WriteData (WriteData),
        .Busy      (Busy),
        .Done      (Done),
        .HI        (HI),
        .LO        (LO)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Launch one operation from a negedge in IDLE and check its result.
    // disturb>0: in that busy cycle pulse Start (other operands) and WriteHi.
    // b2b=1: return on the Done cycle so the caller can start the next op there.
    task automatic run_op(input string name, input logic [1:0] op,
                          input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp_hi, input logic [31:0] exp_lo,
                          input int disturb, input bit b2b);
        int  busy_cnt;
        bit  seen;
        Start = 1'b1; Op = op; SrcA = a; SrcB = b;
        @(negedge clk);
        Start = 1'b0;
        busy_cnt = 0;
        seen     = 1'b0;
        for (int k = 0; k < 40; k++) begin
            if (Done) begin
                seen = 1'b1;
                break;
            end
            if (Busy) busy_cnt++;
            if (disturb != 0 && busy_cnt == disturb) begin
                Start = 1'b1; SrcA = 32'd2; SrcB = 32'd2;
                WriteHi = 1'b1; WriteData = 32'hDEAD_BEEF;
            end else begin
                Start = 1'b0; WriteHi = 1'b0;
            end
            @(negedge clk);
        end
        Start = 1'b0; WriteHi = 1'b0;
        check($sformatf("%s/done_seen", name), 64'(seen), 64'd1);
        check($sformatf("%s/busy_cycles", name), 64'(busy_cnt), 64'd33);
        check($sformatf("%s/busy_at_done", name), 64'(Busy), 64'd0);
        check($sformatf("%s/hi", name), 64'(HI), 64'(exp_hi));
        check($sformatf("%s/lo", name), 64'(LO), 64'(exp_lo));
        if (!b2b) begin
            @(negedge clk);
            check($sformatf("%s/done_one_cycle", name), 64'(Done), 64'd0);
            check($sformatf("%s/idle_busy", name), 64'(Busy), 64'd0);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int done_seen;
        rst_n = 1'b0; Start = 1'b0; Op = 2'b00; SrcA = 32'd0; SrcB = 32'd0;
        Flush = 1'b0; WriteHi = 1'b0; WriteLo = 1'b0; WriteData = 32'd0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("reset/busy", 64'(Busy), 64'd0);
        check("reset/done", 64'(Done), 64'd0);
        check("reset/hi",   64'(HI),   64'd0);
        check("reset/lo",   64'(LO),   64'd0);

        // Multiplies
        run_op("multu_max", 2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 0, 1'b0);
        run_op("mult_m3x5", 2'b01, 32'hFFFF_FFFD, 32'd5,         32'hFFFF_FFFF, 32'hFFFF_FFF1, 0, 1'b0);
        run_op("mult_min2", 2'b01, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, 0, 1'b0);

        // Divides
        run_op("div_m7d2",  2'b11, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD, 0, 1'b0);
        run_op("div_7dm2",  2'b11, 32'd7,         32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD, 0, 1'b0);
        run_op("divu_100_7",2'b10, 32'd100,       32'd7,         32'd2,         32'd14,        0, 1'b1);
        // Back-to-back: started in the Done cycle of the previous op
        run_op("div_by0",   2'b11, 32'h1234_5678, 32'd0,         32'h1234_5678, 32'hFFFF_FFFF, 0, 1'b0);
        run_op("div_neg_by0",2'b11,32'hFFFF_FFF8, 32'd0,         32'hFFFF_FFF8, 32'hFFFF_FFFF, 0, 1'b0);
        run_op("divu_by0",  2'b10, 32'h8000_0001, 32'd0,         32'h8000_0001, 32'hFFFF_FFFF, 0, 1'b0);

        // MTHI and MTLO in the same cycle
        WriteHi = 1'b1; WriteLo = 1'b1; WriteData = 32'h0000_1234;
        @(negedge clk);
        WriteHi = 1'b0; WriteLo = 1'b0;
        check("mthilo_both/hi", 64'(HI), 64'h1234);
        check("mthilo_both/lo", 64'(LO), 64'h1234);

        // MTHI then MTLO on separate idle cycles
        WriteHi = 1'b1; WriteData = 32'hAAAA_0000;
        @(negedge clk);
        WriteHi = 1'b0; WriteLo = 1'b1; WriteData = 32'h0000_5555;
        check("mthi/hi", 64'(HI), 64'hAAAA_0000);
        check("mthi/lo_untouched", 64'(LO), 64'h1234);
        @(negedge clk);
        WriteLo = 1'b0;
        check("mtlo/lo", 64'(LO), 64'h5555);

        // DIVU 9/4 flushed in the 10th CALC cycle
        Start = 1'b1; Op = 2'b10; SrcA = 32'd9; SrcB = 32'd4;
        @(negedge clk);
        Start = 1'b0;
        repeat (9) @(negedge clk);
        check("flush/busy_before", 64'(Busy), 64'd1);
        Flush = 1'b1;
        @(negedge clk);
        Flush = 1'b0;
        check("flush/busy_after", 64'(Busy), 64'd0);
        check("flush/done", 64'(Done), 64'd0);
        check("flush/hi", 64'(HI), 64'hAAAA_0000);
        check("flush/lo", 64'(LO), 64'h5555);
        done_seen = 0;
        for (int k = 0; k < 30; k++) begin
            if (Done || Busy) done_seen++;
            @(negedge clk);
        end
        check("flush/no_late_activity", 64'(done_seen), 64'd0);
        check("flush/hi_hold", 64'(HI), 64'hAAAA_0000);

        // MULTU 6*7 with a stray Start and WriteHi in busy cycle 5
        run_op("multu_6x7_dist", 2'b00, 32'd6, 32'd7, 32'd0, 32'd42, 5, 1'b0);

        // Start + Flush (+WriteHi) in the same idle cycle: nothing happens
        Start = 1'b1; Flush = 1'b1; Op = 2'b00; SrcA = 32'd3; SrcB = 32'd3;
        WriteHi = 1'b1; WriteData = 32'h7777_7777;
        @(negedge clk);
        Start = 1'b0; Flush = 1'b0; WriteHi = 1'b0;
        check("start_flush/busy", 64'(Busy), 64'd0);
        check("start_flush/hi", 64'(HI), 64'd0);
        @(negedge clk);
        check("start_flush/busy2", 64'(Busy), 64'd0);
        check("start_flush/done", 64'(Done), 64'd0);

        // Give HI a non-zero value, then reset asynchronously mid-CALC
        WriteHi = 1'b1; WriteData = 32'h0F0F_0F0F;
        @(negedge clk);
        WriteHi = 1'b0;
        check("mthi2/hi", 64'(HI), 64'h0F0F_0F0F);
        Start = 1'b1; Op = 2'b00; SrcA = 32'd5; SrcB = 32'd5;
        @(negedge clk);
        Start = 1'b0;
        repeat (5) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst/busy", 64'(Busy), 64'd0);
        check("async_rst/done", 64'(Done), 64'd0);
        check("async_rst/hi",   64'(HI),   64'd0);
        check("async_rst/lo",   64'(LO),   64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("after_rst/busy", 64'(Busy), 64'd0);
        run_op("multu_3x4", 2'b00, 32'd3, 32'd4, 32'd0, 32'd12, 0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
